// File: rtl/pkt_truncate_if.sv
// ============================================================================
//  Module      : pkt_truncate_if
//  Description : Upstream/downstream stream handshake bundle for pkt_truncate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pkt_truncate_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;

    // Environment side: drives upstream beats and downstream ready
    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );

    // Truncator side
    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

`default_nettype wire

// File: rtl/pkt_truncate.sv
// ============================================================================
//  Module      : pkt_truncate
//  Description : Truncates each packet to keep_len beats, discarding the tail.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_truncate #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16,
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic [LEN_W-1:0] keep_len,
    pkt_truncate_if.slave         bus,
    output logic      [CNT_W-1:0] pkt_count,
    output logic      [CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PASS  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_len_eff;
    logic [WIDTH-1:0] r_odata;
    logic [WIDTH-1:0] r_sdata;
    logic             r_olast;
    logic             r_slast;
    logic             r_ovalid;
    logic             r_svalid;
    logic             r_itready;
    logic [CNT_W-1:0] r_pkt;
    logic [CNT_W-1:0] r_drop;

    logic w_acc;
    logic w_keep;
    logic w_drop_beat;
    logic w_trunc;
    logic w_last;
    logic w_pop;
    logic w_out_free;
    logic w_svalid_nxt;

    assign w_acc       = bus.i_tvalid & r_itready;
    assign w_keep      = w_acc & (r_state != ST_DROP);
    assign w_drop_beat = w_acc & (r_state == ST_DROP);

    // The first beat of a packet uses the live keep_len; later beats the latched copy
    assign w_len_eff   = (r_state == ST_START) ? keep_len : r_len;
    assign w_trunc     = (w_len_eff != '0) && (r_cnt == w_len_eff - LEN_W'(1));
    assign w_last      = bus.i_tlast | w_trunc;

    assign w_pop       = r_ovalid & bus.o_tready;
    assign w_out_free  = ~r_ovalid | w_pop;

    always_comb begin
        w_state_nxt = r_state;
        if (w_keep) begin
            if (bus.i_tlast)
                w_state_nxt = ST_START;
            else if (w_trunc)
                w_state_nxt = ST_DROP;
            else
                w_state_nxt = ST_PASS;
        end else if (w_drop_beat && bus.i_tlast) begin
            w_state_nxt = ST_START;
        end

        w_svalid_nxt = r_svalid;
        if (w_out_free)
            w_svalid_nxt = 1'b0;
        else if (w_keep)
            w_svalid_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_START;
            r_len     <= '0;
            r_cnt     <= '0;
            r_odata   <= '0;
            r_olast   <= 1'b0;
            r_ovalid  <= 1'b0;
            r_sdata   <= '0;
            r_slast   <= 1'b0;
            r_svalid  <= 1'b0;
            r_itready <= 1'b0;
            r_pkt     <= '0;
            r_drop    <= '0;
        end else if (clear) begin
            r_state   <= ST_START;
            r_cnt     <= '0;
            r_ovalid  <= 1'b0;
            r_svalid  <= 1'b0;
            r_itready <= 1'b1;
            r_pkt     <= '0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            // DROP must never stall upstream, regardless of buffer occupancy
            r_itready <= (w_state_nxt == ST_DROP) | ~w_svalid_nxt;
            r_svalid  <= w_svalid_nxt;

            if (w_keep && (r_state == ST_START))
                r_len <= keep_len;

            if (w_keep) begin
                if (w_state_nxt != ST_PASS)
                    r_cnt <= '0;
                else if (r_cnt != '1)
                    r_cnt <= r_cnt + LEN_W'(1);
            end

            if (w_out_free) begin
                if (r_svalid) begin
                    r_odata  <= r_sdata;
                    r_olast  <= r_slast;
                    r_ovalid <= 1'b1;
                end else if (w_keep) begin
                    r_odata  <= bus.i_tdata;
                    r_olast  <= w_last;
                    r_ovalid <= 1'b1;
                end else begin
                    r_ovalid <= 1'b0;
                end
            end else if (w_keep) begin
                r_sdata <= bus.i_tdata;
                r_slast <= w_last;
            end

            if (w_pop && r_olast && (r_pkt != '1))
                r_pkt <= r_pkt + CNT_W'(1);
            if (w_drop_beat && (r_drop != '1))
                r_drop <= r_drop + CNT_W'(1);
        end
    end

    assign bus.i_tready = r_itready;
    assign bus.o_tdata  = r_odata;
    assign bus.o_tlast  = r_olast;
    assign bus.o_tvalid = r_ovalid;
    assign pkt_count    = r_pkt;
    assign drop_count   = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_pkt_truncate.sv
// ============================================================================
//  Module      : tb_pkt_truncate
//  Description : Self-checking bench for pkt_truncate with a packet-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_truncate;
    localparam int WIDTH = 32;
    localparam int LEN_W = 16;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [LEN_W-1:0] keep_len = '0;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] drop_count;

    pkt_truncate_if #(.WIDTH(WIDTH)) bus ();

    pkt_truncate #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .keep_len   (keep_len),
        .bus        (bus.slave),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [WIDTH-1:0] d; logic l; } beat_t;
    typedef struct { int keep; int len; int outs; int drops; } vec_t;

    beat_t       exp_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_out = 0;
    int          m_idx = 0;
    int          m_len = 0;
    int          m_pkt = 0;
    int          m_drop = 0;
    bit          rand_rdy = 1'b0;
    bit          fixed_rdy = 1'b1;
    bit          prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_d;
    logic        prev_l;
    logic [WIDTH-1:0] seq = 32'h1000;

    task automatic check(input string name, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: the first keep_len beats of each packet survive
    task automatic model_in(input logic [WIDTH-1:0] d, input logic l);
        beat_t b;
        if (m_idx == 0) m_len = int'(keep_len);
        if (m_len == 0 || m_idx < m_len) begin
            b.d = d;
            b.l = l || (m_len != 0 && m_idx == m_len - 1);
            exp_q.push_back(b);
        end else if (m_drop < CNT_MAX) begin
            m_drop++;
        end
        m_idx = l ? 0 : m_idx + 1;
    endtask

    // One clock: observe what transfers at the coming edge, then step past it
    task automatic tick();
        beat_t b;
        @(negedge clk);
        if (!reset || clear) begin
            exp_q.delete();
            m_idx = 0;
            m_pkt = 0;
            m_drop = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.i_tvalid && bus.i_tready) model_in(bus.i_tdata, bus.i_tlast);
            if (prev_stall)
                check("stall_hold", {bus.o_tvalid, bus.o_tlast, bus.o_tdata},
                      {1'b1, prev_l, prev_d});
            if (bus.o_tvalid && bus.o_tready) begin
                prev_stall = 1'b0;
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", bus.o_tdata, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("out_beat", {bus.o_tlast, bus.o_tdata}, {b.l, b.d});
                    if (b.l && m_pkt < CNT_MAX) m_pkt++;
                end
            end else if (bus.o_tvalid) begin
                prev_stall = 1'b1;
                prev_d = bus.o_tdata;
                prev_l = bus.o_tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    endtask

    task automatic send_beats(input int n, input bit last_end, input bit gaps);
        bit rdy;
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.i_tvalid = 1'b0;
                tick();
            end
            bus.i_tdata  = seq;
            bus.i_tlast  = last_end && (i == n - 1);
            bus.i_tvalid = 1'b1;
            seq = seq + 1;
            t = 0;
            forever begin
                rdy = bus.i_tready;
                tick();
                if (rdy) break;
                t++;
                if (t > 500) begin
                    check("accept_timeout", 0, 1);
                    break;
                end
            end
        end
        bus.i_tvalid = 1'b0;
        bus.i_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.o_tvalid) && t < 3000) begin
            tick();
            t++;
        end
        check("drain_done", (exp_q.size() == 0 && !bus.o_tvalid), 1);
    endtask

    task automatic check_counts();
        check("pkt_count", pkt_count, m_pkt);
        check("drop_count", drop_count, m_drop);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_state", {bus.o_tvalid, bus.i_tready, pkt_count, drop_count},
              {1'b1 == 1'b0, 1'b1, {CNT_W{1'b0}}, {CNT_W{1'b0}}});
    endtask

    vec_t vt[8];
    int   o0;
    int   len;
    int   n1;

    initial begin
        vt = '{'{4, 10, 4, 6}, '{4, 2, 2, 0}, '{4, 4, 4, 0}, '{1, 1, 1, 0},
               '{1, 4, 1, 3},  '{0, 7, 7, 0}, '{3, 1, 1, 0}, '{2, 5, 2, 3}};
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = '0;
        bus.i_tlast  = 1'b0;
        bus.o_tready = 1'b1;

        repeat (3) tick();
        check("reset_outputs", {bus.o_tvalid, bus.o_tlast, bus.i_tready, bus.o_tdata},
              {1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}});
        check("reset_counts", {pkt_count, drop_count}, 0);
        reset = 1'b1;
        tick();
        check("ready_after_reset", bus.i_tready, 1);

        // Table of single packets, each started from a cleared block
        for (int v = 0; v < 8; v++) begin
            keep_len = LEN_W'(vt[v].keep);
            pulse_clear();
            o0 = n_out;
            send_beats(vt[v].len, 1'b1, 1'b0);
            drain();
            check($sformatf("vec%0d_outs", v), n_out - o0, vt[v].outs);
            check($sformatf("vec%0d_drops", v), drop_count, vt[v].drops);
            check($sformatf("vec%0d_pkts", v), pkt_count, 1);
            check_counts();
        end

        // Short then exact length, back to back
        keep_len = 16'd4;
        pulse_clear();
        send_beats(2, 1'b1, 1'b0);
        send_beats(4, 1'b1, 1'b0);
        drain();
        check("short_exact_pkts", pkt_count, 2);
        check("short_exact_drops", drop_count, 0);

        // Long pass-through
        keep_len = 16'd0;
        pulse_clear();
        o0 = n_out;
        send_beats(300, 1'b1, 1'b0);
        drain();
        check("passthru_outs", n_out - o0, 300);
        check_counts();

        // Drop counter saturation
        keep_len = 16'd1;
        pulse_clear();
        send_beats(300, 1'b1, 1'b0);
        drain();
        check("drop_saturate", drop_count, CNT_MAX);
        check_counts();

        // Random downstream backpressure
        keep_len = 16'd8;
        pulse_clear();
        rand_rdy = 1'b1;
        o0 = n_out;
        for (int p = 0; p < 20; p++) send_beats(12, 1'b1, 1'b0);
        drain();
        rand_rdy = 1'b0;
        tick();
        check("bp_outs", n_out - o0, 160);
        check("bp_pkts", pkt_count, 20);
        check("bp_drops", drop_count, 80);

        // keep_len changed mid-packet takes effect on the next packet
        keep_len = 16'd4;
        pulse_clear();
        o0 = n_out;
        send_beats(2, 1'b0, 1'b0);
        keep_len = 16'd2;
        send_beats(8, 1'b1, 1'b0);
        send_beats(10, 1'b1, 1'b0);
        drain();
        check("midchange_outs", n_out - o0, 6);
        check("midchange_drops", drop_count, 14);
        check_counts();

        // Clear while dropping
        keep_len = 16'd2;
        pulse_clear();
        send_beats(4, 1'b0, 1'b0);
        drain();
        check("pre_clear_drops", drop_count, 2);
        pulse_clear();
        o0 = n_out;
        send_beats(3, 1'b1, 1'b0);
        drain();
        check("post_clear_outs", n_out - o0, 2);
        check("post_clear_pkts", pkt_count, 1);
        check("post_clear_drops", drop_count, 1);

        // Reset with two beats held in the buffer
        keep_len = 16'd0;
        fixed_rdy = 1'b0;
        tick();
        send_beats(2, 1'b0, 1'b0);
        tick();
        check("buffer_full", {bus.o_tvalid, bus.i_tready}, 2'b10);
        reset = 1'b0;
        #1;
        check("async_reset", {bus.o_tvalid, bus.i_tready}, 2'b00);
        tick();
        tick();
        reset = 1'b1;
        fixed_rdy = 1'b1;
        tick();
        o0 = n_out;
        send_beats(3, 1'b1, 1'b0);
        drain();
        check("post_reset_outs", n_out - o0, 3);
        check_counts();

        // Randomized packets, gaps, backpressure and mid-packet keep_len changes
        pulse_clear();
        rand_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            keep_len = LEN_W'($urandom_range(0, 5));
            len = $urandom_range(1, 9);
            n1 = $urandom_range(0, len - 1);
            send_beats(n1, 1'b0, 1'b1);
            keep_len = LEN_W'($urandom_range(0, 5));
            send_beats(len - n1, 1'b1, 1'b1);
        end
        drain();
        rand_rdy = 1'b0;
        tick();
        check_counts();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
